// File: rtl/conv1d_out_pack.sv
// Requantizes signed accumulator results to int8 (round, optional ReLU, saturate),
// packs four per little-endian word and writes them out over an OBI-style req/gnt port.
`timescale 1ns/1ps
module conv1d_out_pack #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CNT_W-1:0]        n_out,
  input  logic [31:0]             base_addr,
  input  logic [4:0]              shift,
  input  logic                    relu_en,
  input  logic                    acc_valid,
  input  logic signed [ACC_W-1:0] acc_data,
  output logic                    acc_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_be,
  input  logic                    mem_gnt,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             sat_cnt
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FIN} state_t;

  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] Q_MIN = (ACC_W+1)'(-128);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cfg_n, out_cnt, word_idx;
  logic [31:0]      cfg_base;
  logic [4:0]       cfg_shift;
  logic             cfg_relu;
  logic [2:0]       lane;
  logic [31:0]      pack_p0;
  logic [15:0]      sat_q;
  logic             vld_p0;
  logic [8:0]       rq_p0;
  logic             last_out;

  // Returns {saturated, int8}; the extra MSB keeps the rounding add from wrapping.
  function automatic logic [8:0] requant(input logic signed [ACC_W-1:0] acc,
                                         input logic [4:0] sh,
                                         input logic relu);
    logic signed [ACC_W:0] rnd, t, y;
    logic                  sat;
    rnd = '0;
    if (sh != 5'd0) rnd = (ACC_W+1)'(1) << (sh - 5'd1);
    t   = $signed({acc[ACC_W-1], acc}) + rnd;
    y   = t >>> sh;
    if (relu && y[ACC_W]) y = '0;
    sat = 1'b0;
    if (y > Q_MAX) begin
      y   = Q_MAX;
      sat = 1'b1;
    end else if (y < Q_MIN) begin
      y   = Q_MIN;
      sat = 1'b1;
    end
    return {sat, y[7:0]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign acc_ready = (state == COLLECT);
  assign vld_p0    = acc_valid && acc_ready;
  assign rq_p0     = requant(acc_data, cfg_shift, cfg_relu);
  assign last_out  = (out_cnt + CNT_W'(1)) == cfg_n;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (n_out == '0) ? FIN : COLLECT;
      COLLECT: if (vld_p0 && (lane == 3'd3 || last_out)) state_nx = WRITE;
      WRITE:   if (mem_gnt) state_nx = (out_cnt == cfg_n) ? FIN : COLLECT;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lane     <= '0;
      out_cnt  <= '0;
      word_idx <= '0;
      sat_q    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        lane     <= '0;
        out_cnt  <= '0;
        word_idx <= '0;
        sat_q    <= '0;
      end
      if (vld_p0) begin
        lane    <= lane + 3'd1;
        out_cnt <= out_cnt + CNT_W'(1);
        if (rq_p0[8]) sat_q <= sat_inc(sat_q);
      end
      if (state == WRITE && mem_gnt) begin
        word_idx <= word_idx + CNT_W'(1);
        lane     <= '0;
      end
    end
  end

  // p0: requantized byte lands in the staging word in the accept cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      cfg_n     <= n_out;
      cfg_base  <= base_addr;
      cfg_shift <= shift;
      cfg_relu  <= relu_en;
      pack_p0   <= '0;
    end
    if (vld_p0) pack_p0[{lane[1:0], 3'b000} +: 8] <= rq_p0[7:0];
    if (state == WRITE && mem_gnt) pack_p0 <= '0;
  end

  always_comb begin
    mem_be = 4'b0000;
    if (state == WRITE) begin
      case (lane)
        3'd1:    mem_be = 4'b0001;
        3'd2:    mem_be = 4'b0011;
        3'd3:    mem_be = 4'b0111;
        3'd4:    mem_be = 4'b1111;
        default: mem_be = 4'b0000;
      endcase
    end
  end

  assign mem_req   = (state == WRITE);
  assign mem_we    = mem_req;
  assign mem_addr  = mem_req ? cfg_base + {{(30-CNT_W){1'b0}}, word_idx, 2'b00} : '0;
  assign mem_wdata = mem_req ? pack_p0 : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign sat_cnt   = sat_q;

endmodule

// File: tb/tb_conv1d_out_pack.sv
// Bench for conv1d_out_pack: directed cases plus randomized layers scored against
// a plain-arithmetic requantize/pack reference model.
`timescale 1ns/1ps
module tb_conv1d_out_pack;
  localparam int ACC_W = 32;
  localparam int CNT_W = 12;

  logic              clk = 1'b0;
  logic              reset, start, relu_en, acc_valid, acc_ready;
  logic [CNT_W-1:0]  n_out;
  logic [31:0]       base_addr, mem_addr, mem_wdata;
  logic [4:0]        shift;
  logic signed [31:0] acc_data;
  logic              mem_req, mem_we, mem_gnt, busy, done;
  logic [3:0]        mem_be;
  logic [15:0]       sat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int          q_acc[$];
  logic [31:0] o_addr[$], o_data[$];
  logic [3:0]  o_be[$];
  int          o_sat, o_dur;
  bit          o_timeout;

  logic [31:0] e_addr[$], e_data[$];
  logic [3:0]  e_be[$];
  int          e_sat;

  conv1d_out_pack #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .n_out(n_out), .base_addr(base_addr),
    .shift(shift), .relu_en(relu_en), .acc_valid(acc_valid), .acc_data(acc_data),
    .acc_ready(acc_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt), .busy(busy),
    .done(done), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  // Reference: round-half-up arithmetic shift, ReLU, clamp to int8.
  function automatic void ref_q(input int acc, input int sh, input bit relu,
                                output logic [7:0] b, output bit sat);
    longint t, y;
    t = longint'(acc) + ((sh > 0) ? (longint'(1) << (sh - 1)) : 64'sd0);
    y = t >>> sh;
    if (relu && y < 0) y = 0;
    sat = 1'b0;
    if (y > 127) begin y = 127; sat = 1'b1; end
    else if (y < -128) begin y = -128; sat = 1'b1; end
    b = y[7:0];
  endfunction

  task automatic build_expected(input int n, input logic [31:0] base, input int sh, input bit relu);
    logic [31:0] w;
    logic [7:0]  b;
    bit          s;
    e_addr.delete(); e_data.delete(); e_be.delete();
    e_sat = 0;
    w = '0;
    for (int i = 0; i < n; i++) begin
      ref_q(q_acc[i], sh, relu, b, s);
      if (s && e_sat < 65535) e_sat++;
      w = w | (32'(b) << (8 * (i % 4)));
      if (i % 4 == 3 || i == n - 1) begin
        e_addr.push_back(base + 32'(4 * (i / 4)));
        e_data.push_back(w);
        e_be.push_back(4'((1 << (i % 4 + 1)) - 1));
        w = '0;
      end
    end
  endtask

  // Drives one layer; gwait<0 picks a random 0..3 grant delay per request.
  task automatic run_layer(input int n, input logic [31:0] base, input int sh, input bit relu,
                           input int gwait, input int vprob, input bit stray);
    int idx, cyc, age, wcur, last_gnt;
    bit prev_stall;
    logic [31:0] pa, pd;
    logic [3:0]  pb;
    o_addr.delete(); o_data.delete(); o_be.delete();
    o_timeout = 0; o_sat = -1; o_dur = -1;
    idx = 0; age = 0; last_gnt = -10; prev_stall = 0;
    wcur = (gwait < 0) ? int'($urandom_range(0, 3)) : gwait;
    pa = '0; pd = '0; pb = '0;
    @(negedge clk);
    start = 1'b1; n_out = n[CNT_W-1:0]; base_addr = base; shift = sh[4:0]; relu_en = relu;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    forever begin
      if (done) begin
        o_sat = int'(sat_cnt);
        o_dur = cyc;
        if (n > 0) begin
          n_cmp++;
          if (last_gnt != cyc - 1) begin
            n_bad++;
            $display("FAIL done_after_grant: done at cycle %0d, required cycle %0d", cyc, last_gnt + 1);
          end
        end
        break;
      end
      if (cyc > 3000) begin
        o_timeout = 1;
        break;
      end
      if (prev_stall) begin
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== pa || mem_wdata !== pd || mem_be !== pb) begin
          n_bad++;
          $display("FAIL stall_stable: req=%b addr=%h data=%h be=%h, required req=1 addr=%h data=%h be=%h",
                   mem_req, mem_addr, mem_wdata, mem_be, pa, pd, pb);
        end
        n_cmp++;
        if (acc_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL stall_ready: acc_ready=%b, required 0", acc_ready);
        end
      end
      if (stray && cyc == 2) begin
        start = 1'b1; n_out = 12'd1; base_addr = 32'hFFFF_0000; shift = 5'd7; relu_en = ~relu;
      end else begin
        start = 1'b0;
      end
      mem_gnt = mem_req && (age >= wcur);
      if (mem_req && mem_gnt) begin
        o_addr.push_back(mem_addr); o_data.push_back(mem_wdata); o_be.push_back(mem_be);
        if (mem_we !== 1'b1) begin
          n_cmp++; n_bad++;
          $display("FAIL mem_we: got %b, required 1", mem_we);
        end
        age = 0;
        wcur = (gwait < 0) ? int'($urandom_range(0, 3)) : gwait;
        last_gnt = cyc;
      end else if (mem_req) begin
        age++;
      end
      prev_stall = mem_req && !mem_gnt;
      pa = mem_addr; pd = mem_wdata; pb = mem_be;
      acc_valid = (idx < n) && (int'($urandom_range(1, 100)) <= vprob);
      acc_data  = (idx < n) ? q_acc[idx] : $urandom;
      if (acc_valid && acc_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; acc_valid = 1'b0; mem_gnt = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({acc_ready, mem_req, mem_we, busy, done} !== 5'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || mem_be !== 4'h0 || sat_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_values: rdy=%b req=%b we=%b busy=%b done=%b addr=%h data=%h be=%h sat=%h, required all 0",
               acc_ready, mem_req, mem_we, busy, done, mem_addr, mem_wdata, mem_be, sat_cnt);
    end
  endtask

  task automatic test_basic_pack();
    q_acc = '{1, -1, 127, -128};
    run_layer(4, 32'h1000, 0, 1'b0, 0, 100, 1'b0);
    n_cmp++;
    if (o_timeout || o_addr.size() != 1) begin
      n_bad++;
      $display("FAIL basic_writes: got %0d writes timeout=%0d, required 1", o_addr.size(), o_timeout);
    end else begin
      n_cmp++;
      if (o_addr[0] !== 32'h1000 || o_data[0] !== 32'h807F_FF01 || o_be[0] !== 4'hF) begin
        n_bad++;
        $display("FAIL basic_word: addr=%h data=%h be=%h, required 00001000 807fff01 f", o_addr[0], o_data[0], o_be[0]);
      end
    end
    n_cmp++;
    if (o_sat != 0) begin n_bad++; $display("FAIL basic_sat: got %0d, required 0", o_sat); end
    n_cmp++;
    if (o_dur != 6) begin n_bad++; $display("FAIL basic_latency: done %0d cycles after start, required 6", o_dur); end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_round_sat();
    q_acc = '{24, -24, 5000, -5000};
    run_layer(4, 32'h2000, 4, 1'b0, 0, 100, 1'b0);
    n_cmp++;
    if (o_timeout || o_data.size() != 1 || o_data[0] !== 32'h807F_FF02) begin
      n_bad++;
      $display("FAIL round_sat_word: writes=%0d data=%h, required 1 write of 807fff02",
               o_data.size(), (o_data.size() > 0) ? o_data[0] : 32'h0);
    end
    n_cmp++;
    if (o_sat != 2) begin n_bad++; $display("FAIL round_sat_cnt: got %0d, required 2", o_sat); end
  endtask

  task automatic test_relu_partial();
    q_acc = '{-5, 3, 300, -300, 7, -1};
    run_layer(6, 32'h3000, 0, 1'b1, 1, 70, 1'b0);
    n_cmp++;
    if (o_timeout || o_data.size() != 2) begin
      n_bad++;
      $display("FAIL relu_writes: got %0d writes timeout=%0d, required 2", o_data.size(), o_timeout);
    end else begin
      n_cmp++;
      if (o_addr[0] !== 32'h3000 || o_data[0] !== 32'h007F_0300 || o_be[0] !== 4'hF) begin
        n_bad++;
        $display("FAIL relu_word0: addr=%h data=%h be=%h, required 00003000 007f0300 f", o_addr[0], o_data[0], o_be[0]);
      end
      n_cmp++;
      if (o_addr[1] !== 32'h3004 || o_data[1] !== 32'h0000_0007 || o_be[1] !== 4'h3) begin
        n_bad++;
        $display("FAIL relu_word1: addr=%h data=%h be=%h, required 00003004 00000007 3", o_addr[1], o_data[1], o_be[1]);
      end
    end
    n_cmp++;
    if (o_sat != 1) begin n_bad++; $display("FAIL relu_sat: got %0d, required 1", o_sat); end
  endtask

  task automatic test_backpressure();
    q_acc = '{10, 11, 12, 13, 14, 15, 16, 17};
    run_layer(8, 32'h0200, 0, 1'b0, 3, 100, 1'b0);
    n_cmp++;
    if (o_timeout || o_data.size() != 2 || o_data[0] !== 32'h0D0C_0B0A || o_data[1] !== 32'h1110_0F0E ||
        o_addr[0] !== 32'h0200 || o_addr[1] !== 32'h0204) begin
      n_bad++;
      $display("FAIL backpressure_words: writes=%0d d0=%h d1=%h, required 0d0c0b0a@200 11100f0e@204",
               o_data.size(), (o_data.size() > 0) ? o_data[0] : 32'h0, (o_data.size() > 1) ? o_data[1] : 32'h0);
    end
  endtask

  task automatic test_zero_count();
    q_acc.delete();
    run_layer(0, 32'h4000, 0, 1'b0, 0, 100, 1'b0);
    n_cmp++;
    if (o_timeout || o_addr.size() != 0 || o_dur < 1 || o_dur > 2) begin
      n_bad++;
      $display("FAIL zero_count: writes=%0d done_after=%0d timeout=%0d, required 0 writes, done within 2",
               o_addr.size(), o_dur, o_timeout);
    end
  endtask

  task automatic test_ignored_start();
    q_acc = '{-900, 64, 33, 2};
    run_layer(4, 32'h5000, 2, 1'b0, 0, 100, 1'b1);
    build_expected(4, 32'h5000, 2, 1'b0);
    n_cmp++;
    if (o_timeout || o_data.size() != 1 || o_data[0] !== e_data[0] || o_addr[0] !== e_addr[0] || o_sat != e_sat) begin
      n_bad++;
      $display("FAIL ignored_start: writes=%0d data=%h sat=%0d, required %h sat=%0d",
               o_data.size(), (o_data.size() > 0) ? o_data[0] : 32'h0, o_sat, e_data[0], e_sat);
    end
  endtask

  task automatic test_reset_mid();
    int k, reqs;
    @(negedge clk);
    start = 1'b1; n_out = 12'd4; base_addr = 32'h6000; shift = 5'd0; relu_en = 1'b0;
    @(negedge clk);
    start = 1'b0; acc_valid = 1'b1; acc_data = 32'sd1000; mem_gnt = 1'b0;
    k = 0;
    while (!mem_req && k < 20) begin @(negedge clk); k++; end
    acc_valid = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b1 || sat_cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL reset_mid_setup: req=%b sat=%0d, required 1 4", mem_req, sat_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_req || busy) reqs++;
    end
    n_cmp++;
    if (reqs != 0) begin n_bad++; $display("FAIL reset_mid_quiet: %0d active cycles, required 0", reqs); end
  endtask

  task automatic test_random();
    int n, sh;
    bit relu;
    logic [31:0] base;
    for (int l = 0; l < 8; l++) begin
      n = int'($urandom_range(1, 13));
      sh = int'($urandom_range(0, 31));
      relu = 1'($urandom_range(0, 1));
      base = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      q_acc.delete();
      for (int i = 0; i < n; i++)
        q_acc.push_back(($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 600)) - 300);
      run_layer(n, base, sh, relu, -1, 60, 1'b0);
      build_expected(n, base, sh, relu);
      n_cmp++;
      if (o_timeout || o_data.size() != e_data.size()) begin
        n_bad++;
        $display("FAIL rand_count[%0d]: writes=%0d timeout=%0d, required %0d", l, o_data.size(), o_timeout, e_data.size());
      end else begin
        for (int w = 0; w < e_data.size(); w++) begin
          n_cmp++;
          if (o_addr[w] !== e_addr[w] || o_data[w] !== e_data[w] || o_be[w] !== e_be[w]) begin
            n_bad++;
            $display("FAIL rand_word[%0d.%0d]: addr=%h data=%h be=%h, required %h %h %h",
                     l, w, o_addr[w], o_data[w], o_be[w], e_addr[w], e_data[w], e_be[w]);
          end
        end
      end
      n_cmp++;
      if (o_sat != e_sat) begin n_bad++; $display("FAIL rand_sat[%0d]: got %0d, required %0d", l, o_sat, e_sat); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; n_out = '0; base_addr = '0; shift = '0; relu_en = 1'b0;
    acc_valid = 1'b0; acc_data = '0; mem_gnt = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic_pack();
    test_round_sat();
    test_relu_partial();
    test_backpressure();
    test_zero_count();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
